// File: rtl/falling_obj_pkg.sv
// Shared types and constants for the falling-object engine.
//   slot_state_t : per-slot FSM encoding (IDLE / FALLING)
//   LFSR_TAPS    : Galois feedback mask for taps 16,14,13,11
//   DEF_*        : default geometry, used as parameter defaults by the engine
//   lfsr_step    : one right-shift Galois step
package falling_obj_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        FALLING = 1'b1
    } slot_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_LANES     = 8;
    localparam int DEF_LANE_W    = 80;
    localparam int DEF_SPRITE_H  = 80;
    localparam int DEF_SCREEN_H  = 480;
    localparam int DEF_CATCH_Y   = 400;
    localparam int DEF_STEP      = 1;
    localparam int DEF_SPAWN_MIN = 16;

    // Object y positions live in the same 10-bit space as v_cnt.
    localparam int Y_W = 10;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/obj_slot.sv
// One falling-object slot: FSM plus y / lane / respawn-delay registers.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           effective tick (tick & ~pause); all state holds when low
//   lfsr_lane    lfsr[2:0], lane seed used at spawn
//   lfsr_delay   lfsr[7:4], extra respawn delay loaded at spawn
//   farmer_x     farmer lane
//   state        1 while FALLING (debug view of the FSM)
//   y, lane      current object position
//   caught       this effective tick catches the object
//   missed       this effective tick drops the object past the catch zone
module obj_slot
    import falling_obj_pkg::*;
#(
    parameter int IDX       = 0,
    parameter int LANES     = 8,
    parameter int LANE_BITS = 3,
    parameter int DELAY_W   = 8,
    parameter int SPRITE_H  = 80,
    parameter int CATCH_Y   = 400,
    parameter int STEP      = 1,
    parameter int SPAWN_MIN = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [2:0]           lfsr_lane,
    input  logic [3:0]           lfsr_delay,
    input  logic [2:0]           farmer_x,
    output logic                 state,
    output logic [Y_W-1:0]       y,
    output logic [LANE_BITS-1:0] lane,
    output logic                 caught,
    output logic                 missed
);

    slot_state_t          state_q, state_d;
    logic [Y_W-1:0]       y_q;
    logic [LANE_BITS-1:0] lane_q;
    logic [DELAY_W-1:0]   delay_q;

    logic                 spawn;
    logic                 catch_now;
    logic                 miss_now;
    logic [3:0]           lane_sum;
    logic [LANE_BITS-1:0] spawn_lane;

    // Condition decode. Adding IDX to the seed keeps slots that spawn on
    // the same tick in distinct lanes.
    always_comb begin
        spawn      = (delay_q == '0);
        lane_sum   = {1'b0, lfsr_lane} + 4'(IDX);
        spawn_lane = LANE_BITS'(32'(lane_sum) % LANES);
        catch_now  = (32'(farmer_x) < LANES) &&
                     (32'(lane_q) == 32'(farmer_x)) &&
                     (32'(y_q) + SPRITE_H >= CATCH_Y) &&
                     (32'(y_q) < CATCH_Y);
        // A catch takes precedence over a miss on the same tick.
        miss_now   = !catch_now && (32'(y_q) + STEP >= CATCH_Y);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                IDLE:    if (spawn) state_d = FALLING;
                FALLING: if (catch_now || miss_now) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        state  = (state_q == FALLING);
        caught = en && (state_q == FALLING) && catch_now;
        missed = en && (state_q == FALLING) && miss_now;
    end

    // Position and respawn-delay registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            lane_q  <= '0;
            delay_q <= DELAY_W'(IDX * SPAWN_MIN);
        end else if (en) begin
            if (state_q == IDLE) begin
                if (!spawn) begin
                    delay_q <= delay_q - 1'b1;
                end else begin
                    y_q     <= '0;
                    lane_q  <= spawn_lane;
                    delay_q <= DELAY_W'(SPAWN_MIN) + DELAY_W'(lfsr_delay);
                end
            end else if (!catch_now && !miss_now) begin
                y_q <= y_q + Y_W'(STEP);
            end
        end
    end

    assign y    = y_q;
    assign lane = lane_q;

endmodule

// File: rtl/falling_object_engine.sv
// Falling-object engine: NUM_OBJ slots over LANES columns, LFSR-driven
// spawning, catch/miss scoring and a zero-latency sprite pixel mux.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   tick              one-cycle step enable
//   pause             freezes all object state while high
//   h_cnt, v_cnt      current VGA pixel
//   farmer_x          farmer lane
//   pixel_addr        sprite ROM address for the current pixel
//   show              an object covers the current pixel
//   hit_id            slot owning the current pixel
//   score_pos/neg     saturating good / bad score
//   catch_pulse       one-cycle pulse after a tick with any catch
//   miss_pulse        one-cycle pulse after a tick with a good-object miss
module falling_object_engine
    import falling_obj_pkg::*;
#(
    parameter int          NUM_OBJ   = 4,
    parameter int          LANES     = DEF_LANES,
    parameter int          LANE_W    = DEF_LANE_W,
    parameter int          SPRITE_H  = DEF_SPRITE_H,
    parameter int          SCREEN_H  = DEF_SCREEN_H,
    parameter int          CATCH_Y   = DEF_CATCH_Y,
    parameter int          STEP      = DEF_STEP,
    parameter int          SCORE_W   = 8,
    parameter logic [31:0] WEIGHTS   = 32'h3321,
    parameter logic [7:0]  BAD_MASK  = 8'b0000_0001,
    parameter int          SPAWN_MIN = DEF_SPAWN_MIN,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               pause,
    input  logic [9:0]         h_cnt,
    input  logic [9:0]         v_cnt,
    input  logic [2:0]         farmer_x,
    output logic [16:0]        pixel_addr,
    output logic               show,
    output logic [2:0]         hit_id,
    output logic [SCORE_W-1:0] score_pos,
    output logic [SCORE_W-1:0] score_neg,
    output logic               catch_pulse,
    output logic               miss_pulse
);

    localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int DELAY_W   = $clog2(SPAWN_MIN * 8 + 16);

    logic                 step_en;
    logic [15:0]          lfsr_q;

    logic [NUM_OBJ-1:0]   slot_falling;
    logic [NUM_OBJ-1:0]   slot_caught;
    logic [NUM_OBJ-1:0]   slot_missed;
    logic [NUM_OBJ-1:0]   slot_cover;
    logic [Y_W-1:0]       slot_y    [NUM_OBJ];
    logic [LANE_BITS-1:0] slot_lane [NUM_OBJ];
    logic [16:0]          slot_addr [NUM_OBJ];

    logic [7:0]           pos_sum;
    logic [7:0]           neg_sum;

    assign step_en = tick && !pause;

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_slot
        logic [31:0] x0;

        obj_slot #(
            .IDX       (i),
            .LANES     (LANES),
            .LANE_BITS (LANE_BITS),
            .DELAY_W   (DELAY_W),
            .SPRITE_H  (SPRITE_H),
            .CATCH_Y   (CATCH_Y),
            .STEP      (STEP),
            .SPAWN_MIN (SPAWN_MIN)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (step_en),
            .lfsr_lane  (lfsr_q[2:0]),
            .lfsr_delay (lfsr_q[7:4]),
            .farmer_x   (farmer_x),
            .state      (slot_falling[i]),
            .y          (slot_y[i]),
            .lane       (slot_lane[i]),
            .caught     (slot_caught[i]),
            .missed     (slot_missed[i])
        );

        assign x0 = 32'(slot_lane[i]) * 32'(LANE_W);

        assign slot_cover[i] = slot_falling[i] &&
                               (32'(h_cnt) >= x0) &&
                               (32'(h_cnt) < x0 + 32'(LANE_W)) &&
                               (32'(v_cnt) >= 32'(slot_y[i])) &&
                               (32'(v_cnt) < 32'(slot_y[i]) + 32'(SPRITE_H)) &&
                               (32'(v_cnt) < 32'(SCREEN_H));

        // Only meaningful while slot_cover[i] is set.
        assign slot_addr[i] = 17'(32'(i * LANE_W * SPRITE_H) +
                                  (32'(h_cnt) - x0) +
                                  32'(LANE_W) * (32'(v_cnt) - 32'(slot_y[i])));
    end

    // All weights caught on one tick are summed before the saturating add.
    always_comb begin
        pos_sum = '0;
        neg_sum = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (slot_caught[i]) begin
                if (BAD_MASK[i]) neg_sum = neg_sum + 8'(WEIGHTS[4*i +: 4]);
                else             pos_sum = pos_sum + 8'(WEIGHTS[4*i +: 4]);
            end
        end
    end

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [7:0] b);
        logic [SCORE_W+8:0] s;
        s = (SCORE_W+9)'(a) + (SCORE_W+9)'(b);
        if (s > (SCORE_W+9)'({SCORE_W{1'b1}})) return '1;
        return s[SCORE_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q      <= LFSR_SEED;
            score_pos   <= '0;
            score_neg   <= '0;
            catch_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
        end else if (step_en) begin
            lfsr_q      <= lfsr_step(lfsr_q);
            score_pos   <= sat_add(score_pos, pos_sum);
            score_neg   <= sat_add(score_neg, neg_sum);
            catch_pulse <= |slot_caught;
            miss_pulse  <= |(slot_missed & ~BAD_MASK[NUM_OBJ-1:0]);
        end else begin
            catch_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
        end
    end

    // Lowest covering slot wins: scan from the top so lower indices override.
    always_comb begin
        show       = 1'b0;
        hit_id     = '0;
        pixel_addr = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (slot_cover[i]) begin
                show       = 1'b1;
                hit_id     = 3'(i);
                pixel_addr = slot_addr[i];
            end
        end
    end

endmodule
